// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake and completion status bundle for the
// PS/2 host transmitter. The master side offers command bytes and observes
// the one-cycle completion pulse; the slave side is the transmitter itself.
interface ps2_host_tx_if;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       done;
  logic       ack_ok;
  logic       err_noack;
  logic       err_timeout;

  modport master (
    output cmd_valid, cmd_data,
    input  cmd_ready, done, ack_ok, err_noack, err_timeout
  );

  modport slave (
    input  cmd_valid, cmd_data,
    output cmd_ready, done, ack_ok, err_noack, err_timeout
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter. Accepts one command byte,
// runs the request-to-send sequence (clock inhibit, start bit), shifts out
// 8 data bits LSB first, odd parity and stop on device clock falls, then
// samples the device ACK. Both pins are driven open-drain through *_oe.
// Optional feature macro: PS2_TX_RETRY_EN -- on NACK or timeout the same
// byte is re-sent up to MAX_RETRIES extra times before status is reported.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES       = 6000,
  parameter int START_TIMEOUT_CYCLES = 750000,
  parameter int XFER_TIMEOUT_CYCLES  = 100000,
  parameter int MAX_RETRIES          = 2
) (
  input  logic         CLOCK_50,
  input  logic         resetn,
  ps2_host_tx_if.slave cmd,
  input  logic         ps2_clk_in,
  input  logic         ps2_dat_in,
  output logic         ps2_clk_oe,
  output logic         ps2_dat_oe,
  output logic         tx_active
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int ST_W  = $clog2(START_TIMEOUT_CYCLES + 1);
  localparam int XF_W  = $clog2(XFER_TIMEOUT_CYCLES + 1);
  localparam int RC_W  = $clog2(MAX_RETRIES + 2);
`ifdef PS2_TX_RETRY_EN
  localparam int RETRY_LIMIT = MAX_RETRIES;
`else
  // Single attempt: a zero budget means a failure is always reported.
  localparam int RETRY_LIMIT = 0;
`endif

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE
  } state_t;

  state_t state_reg, state_next;

  logic clk_s1_reg, clk_s2_reg, clk_d_reg;
  logic dat_s1_reg, dat_s2_reg;
  logic fall;

  logic [7:0]       byte_reg, byte_next;
  logic             parity_reg, parity_next;
  logic [3:0]       bit_idx_reg, bit_idx_next;
  logic [INH_W-1:0] inh_cnt_reg, inh_cnt_next;
  logic [ST_W-1:0]  start_tmr_reg, start_tmr_next;
  logic [XF_W-1:0]  xfer_tmr_reg, xfer_tmr_next;
  logic             started_reg, started_next;
  logic             dat_oe_reg, dat_oe_next;
  logic             nack_reg, nack_next;
  logic [RC_W-1:0]  retry_cnt_reg, retry_cnt_next;

  logic ready_c, clk_oe_c, dat_oe_c, done_c, ack_c, noack_c, tmo_c;
  logic begin_attempt, fail_timeout, fail_noack;
  logic in_xfer, timeout, retry_ok, cur_bit;

  // Two-flop synchronisers for the raw pins plus a delayed copy for falls.
  // Idle-high reset values keep a spurious fall from appearing after reset.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      clk_s1_reg <= 1'b1;
      clk_s2_reg <= 1'b1;
      clk_d_reg  <= 1'b1;
      dat_s1_reg <= 1'b1;
      dat_s2_reg <= 1'b1;
    end else begin
      clk_s1_reg <= ps2_clk_in;
      clk_s2_reg <= clk_s1_reg;
      clk_d_reg  <= clk_s2_reg;
      dat_s1_reg <= ps2_dat_in;
      dat_s2_reg <= dat_s1_reg;
    end
  end

  assign fall = clk_d_reg & ~clk_s2_reg;

  // Bit presented on the next device clock fall: data LSB first, parity, stop.
  assign cur_bit = (bit_idx_reg < 4'd8)  ? byte_reg[bit_idx_reg[2:0]] :
                   (bit_idx_reg == 4'd8) ? parity_reg : 1'b1;

  assign in_xfer = (state_reg == SEND) || (state_reg == ACK) ||
                   (state_reg == WAIT_IDLE);

  // Before the first device fall the start timer guards the wait; after it
  // the transfer timer covers the whole frame up to the lines going idle.
  assign timeout = in_xfer &&
                   (started_reg ? (xfer_tmr_reg == XF_W'(XFER_TIMEOUT_CYCLES))
                                : (start_tmr_reg == ST_W'(START_TIMEOUT_CYCLES)));

  assign retry_ok = int'(retry_cnt_reg) < RETRY_LIMIT;

  // State and datapath registers.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      byte_reg      <= '0;
      parity_reg    <= 1'b0;
      bit_idx_reg   <= '0;
      inh_cnt_reg   <= '0;
      start_tmr_reg <= '0;
      xfer_tmr_reg  <= '0;
      started_reg   <= 1'b0;
      dat_oe_reg    <= 1'b0;
      nack_reg      <= 1'b0;
      retry_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      byte_reg      <= byte_next;
      parity_reg    <= parity_next;
      bit_idx_reg   <= bit_idx_next;
      inh_cnt_reg   <= inh_cnt_next;
      start_tmr_reg <= start_tmr_next;
      xfer_tmr_reg  <= xfer_tmr_next;
      started_reg   <= started_next;
      dat_oe_reg    <= dat_oe_next;
      nack_reg      <= nack_next;
      retry_cnt_reg <= retry_cnt_next;
    end
  end

  // Next-state, datapath updates and line/status outputs.
  always_comb begin
    state_next     = state_reg;
    byte_next      = byte_reg;
    parity_next    = parity_reg;
    bit_idx_next   = bit_idx_reg;
    inh_cnt_next   = inh_cnt_reg;
    start_tmr_next = start_tmr_reg;
    xfer_tmr_next  = xfer_tmr_reg;
    started_next   = started_reg;
    dat_oe_next    = dat_oe_reg;
    nack_next      = nack_reg;
    retry_cnt_next = retry_cnt_reg;
    ready_c        = 1'b0;
    clk_oe_c       = 1'b0;
    dat_oe_c       = 1'b0;
    done_c         = 1'b0;
    ack_c          = 1'b0;
    noack_c        = 1'b0;
    tmo_c          = 1'b0;
    begin_attempt  = 1'b0;
    fail_timeout   = 1'b0;
    fail_noack     = 1'b0;

    if (in_xfer) begin
      if (started_reg) xfer_tmr_next  = xfer_tmr_reg + XF_W'(1);
      else             start_tmr_next = start_tmr_reg + ST_W'(1);
    end

    case (state_reg)
      IDLE: begin
        ready_c = 1'b1;
        if (cmd.cmd_valid) begin
          byte_next      = cmd.cmd_data;
          parity_next    = ~^cmd.cmd_data;
          retry_cnt_next = '0;
          begin_attempt  = 1'b1;
        end
      end
      INHIBIT: begin
        clk_oe_c = 1'b1;
        if (inh_cnt_reg == INH_W'(INHIBIT_CYCLES - 1)) begin
          state_next  = REQ;
          dat_oe_next = 1'b1;   // start bit stays asserted into SEND
        end else begin
          inh_cnt_next = inh_cnt_reg + INH_W'(1);
        end
      end
      REQ: begin
        clk_oe_c       = 1'b1;
        dat_oe_c       = 1'b1;
        state_next     = SEND;
        start_tmr_next = '0;
        xfer_tmr_next  = '0;
        started_next   = 1'b0;
      end
      SEND: begin
        if (timeout) begin
          fail_timeout = 1'b1;
        end else begin
          dat_oe_c = dat_oe_reg;
          if (fall) begin
            started_next = 1'b1;
            dat_oe_next  = ~cur_bit;
            bit_idx_next = bit_idx_reg + 4'd1;
            if (bit_idx_reg == 4'd9) state_next = ACK;
          end
        end
      end
      ACK: begin
        if (timeout) begin
          fail_timeout = 1'b1;
        end else if (fall) begin
          nack_next  = dat_s2_reg;
          state_next = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_s2_reg && dat_s2_reg) begin
          if (nack_reg) begin
            fail_noack = 1'b1;
          end else begin
            done_c     = 1'b1;
            ack_c      = 1'b1;
            state_next = IDLE;
          end
        end else if (timeout) begin
          fail_timeout = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (fail_timeout || fail_noack) begin
      if (retry_ok) begin
        retry_cnt_next = retry_cnt_reg + RC_W'(1);
        begin_attempt  = 1'b1;
      end else begin
        done_c      = 1'b1;
        tmo_c       = fail_timeout;
        noack_c     = fail_noack;
        state_next  = IDLE;
        dat_oe_next = 1'b0;
      end
    end

    if (begin_attempt) begin
      state_next   = INHIBIT;
      inh_cnt_next = '0;
      bit_idx_next = '0;
      dat_oe_next  = 1'b0;
    end
  end

  assign cmd.cmd_ready   = ready_c;
  assign cmd.done        = done_c;
  assign cmd.ack_ok      = ack_c;
  assign cmd.err_noack   = noack_c;
  assign cmd.err_timeout = tmo_c;
  assign ps2_clk_oe      = clk_oe_c;
  assign ps2_dat_oe      = dat_oe_c;
  assign tx_active       = ~ready_c;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a behavioural PS/2
// device that clocks the frame, records the bit seen at each rising edge
// and answers with ACK, NACK or silence. Timeouts are scaled down.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH  = 50;
  localparam int STO  = 400;
  localparam int XTO  = 2000;
  localparam int HALF = 20;
`ifdef PS2_TX_RETRY_EN
  localparam int RETRIES = 2;
`else
  localparam int RETRIES = 0;
`endif
  // Status for "NACK once then ACK": ACK when a retry is available.
  localparam int ST_ONCE = (RETRIES > 0) ? 0 : 1;

  localparam int M_ACK = 0, M_NACK = 1, M_SILENT = 2, M_NACK1 = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  ps2_host_tx_if bus();
  logic ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe, tx_active;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;

  // Open-drain wired-AND of host and device drivers.
  assign ps2_clk_in = ~ps2_clk_oe & ~dev_clk_low;
  assign ps2_dat_in = ~ps2_dat_oe & ~dev_dat_low;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH), .START_TIMEOUT_CYCLES(STO),
    .XFER_TIMEOUT_CYCLES(XTO), .MAX_RETRIES(2)
  ) dut (
    .CLOCK_50(clk), .resetn(resetn), .cmd(bus),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .tx_active(tx_active)
  );

  int nvec = 0;
  int nfail = 0;

  // Passive monitor: cumulative event counters, compared as deltas.
  int done_n = 0, ack_n = 0, noack_n = 0, tmo_n = 0;
  int bad_flag_n = 0, oe_at_done_n = 0, inh_n = 0, req_n = 0, phase_n = 0, txa_bad_n = 0;
  logic clk_oe_q = 1'b0;
  always @(negedge clk) begin
    if (bus.done) begin
      done_n  = done_n + 1;
      ack_n   = ack_n + int'(bus.ack_ok);
      noack_n = noack_n + int'(bus.err_noack);
      tmo_n   = tmo_n + int'(bus.err_timeout);
      if (int'(bus.ack_ok) + int'(bus.err_noack) + int'(bus.err_timeout) != 1) bad_flag_n = bad_flag_n + 1;
      if (ps2_clk_oe || ps2_dat_oe) oe_at_done_n = oe_at_done_n + 1;
    end else if (bus.ack_ok || bus.err_noack || bus.err_timeout) begin
      bad_flag_n = bad_flag_n + 1;
    end
    if (ps2_clk_oe && !ps2_dat_oe) inh_n = inh_n + 1;
    if (ps2_clk_oe && ps2_dat_oe)  req_n = req_n + 1;
    if (ps2_clk_oe && !clk_oe_q)   phase_n = phase_n + 1;
    if (tx_active !== ~bus.cmd_ready) txa_bad_n = txa_bad_n + 1;
    clk_oe_q = ps2_clk_oe;
  end

  typedef struct {
    logic [7:0]  data;
    int          mode;
    logic [10:0] frame;   // {stop, parity, d7..d0, start} as seen by the device
    int          st;      // 0 ack_ok, 1 err_noack, 2 err_timeout
    bit          pulse_mid;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    nvec = nvec + 1;
    if (act !== exp) begin
      nfail = nfail + 1;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic offer(input logic [7:0] b);
    @(negedge clk);
    check("cmd_ready_idle", int'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = b;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Waits for an inhibit/request phase and returns at the first cycle
  // after the host has released the clock line.
  task automatic wait_release(output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (!ps2_clk_oe && n < 300) begin @(negedge clk); n++; end
    if (!ps2_clk_oe) return;
    n = 0;
    while (ps2_clk_oe && n < 300) begin @(negedge clk); n++; end
    ok = !ps2_clk_oe;
  endtask

  // One device clock pulse; the data line is read just before the rise.
  task automatic dev_pulse(output logic bit_seen);
    dev_clk_low = 1'b1;
    cycles(HALF);
    bit_seen = ps2_dat_in;
    dev_clk_low = 1'b0;
    cycles(HALF);
  endtask

  task automatic run_txn(input vec_t v);
    int s_done, s_ack, s_noack, s_tmo, s_bad, s_oe, s_inh, s_req, s_phase;
    int n_att, q, exp_q;
    bit ok, ack_this;
    logic [10:0] frame;
    logic b;
    s_done = done_n; s_ack = ack_n; s_noack = noack_n; s_tmo = tmo_n;
    s_bad = bad_flag_n; s_oe = oe_at_done_n; s_inh = inh_n; s_req = req_n; s_phase = phase_n;
    if (v.mode == M_ACK) n_att = 1;
    else if (v.mode == M_NACK1) n_att = (RETRIES > 0) ? 2 : 1;
    else n_att = 1 + RETRIES;

    offer(v.data);
    for (int a = 0; a < n_att; a++) begin
      wait_release(ok);
      check("request_phase", int'(ok), 1);
      if (!ok) break;
      if (v.mode == M_SILENT) begin
        q = 0;
        while (!(bus.done || ps2_clk_oe) && q < STO + 50) begin q++; @(negedge clk); end
        exp_q = (a == n_att - 1) ? STO : STO + 1;
        check("timeout_gap", q, exp_q);
      end else begin
        ack_this = (v.mode == M_ACK) || (v.mode == M_NACK1 && a > 0);
        cycles(10);
        frame = '0;
        frame[0] = ps2_dat_in;
        for (int i = 1; i <= 10; i++) begin
          dev_pulse(b);
          frame[i] = b;
          if (v.pulse_mid && a == 0 && i == 4) begin
            @(negedge clk);
            check("cmd_ready_busy", int'(bus.cmd_ready), 0);
            bus.cmd_valid = 1'b1;
            bus.cmd_data  = ~v.data;
            @(posedge clk);
            #1;
            bus.cmd_valid = 1'b0;
          end
        end
        check("frame_bits", int'(frame), int'(v.frame));
        cycles(5);
        if (ack_this) dev_dat_low = 1'b1;
        cycles(5);
        dev_clk_low = 1'b1;
        cycles(HALF);
        dev_clk_low = 1'b0;
        cycles(5);
        dev_dat_low = 1'b0;
      end
    end
    for (int i = 0; i < 3000 && done_n == s_done; i++) @(negedge clk);
    cycles(20);
    check("done_count",   done_n - s_done, 1);
    check("ack_ok",       ack_n - s_ack, (v.st == 0) ? 1 : 0);
    check("err_noack",    noack_n - s_noack, (v.st == 1) ? 1 : 0);
    check("err_timeout",  tmo_n - s_tmo, (v.st == 2) ? 1 : 0);
    check("flag_excl",    bad_flag_n - s_bad, 0);
    check("oe_at_done",   oe_at_done_n - s_oe, 0);
    check("inhibit_phases", phase_n - s_phase, n_att);
    check("inhibit_cycles", inh_n - s_inh, n_att * INH);
    check("req_cycles",   req_n - s_req, n_att);
    check("ready_after",  int'(bus.cmd_ready), 1);
  endtask

  vec_t vecs[7];
  vec_t v_ff;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic b;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'h00;

    vecs[0] = '{8'hED, M_ACK,    11'b1_1_11101101_0, 0,       1'b0};
    vecs[1] = '{8'h00, M_ACK,    11'b1_1_00000000_0, 0,       1'b0};
    vecs[2] = '{8'hF4, M_ACK,    11'b1_0_11110100_0, 0,       1'b0};
    vecs[3] = '{8'h01, M_ACK,    11'b1_0_00000001_0, 0,       1'b0};
    vecs[4] = '{8'hA5, M_NACK,   11'b1_1_10100101_0, 1,       1'b1};
    vecs[5] = '{8'h55, M_SILENT, 11'b0,              2,       1'b0};
    vecs[6] = '{8'hF3, M_NACK1,  11'b1_1_11110011_0, ST_ONCE, 1'b0};
    v_ff    = '{8'hFF, M_ACK,    11'b1_1_11111111_0, 0,       1'b0};

    // Reset state.
    cycles(3);
    check("rst_cmd_ready", int'(bus.cmd_ready), 1);
    check("rst_clk_oe",    int'(ps2_clk_oe), 0);
    check("rst_dat_oe",    int'(ps2_dat_oe), 0);
    check("rst_done",      int'(bus.done), 0);
    check("rst_tx_active", int'(tx_active), 0);
    resetn = 1'b1;
    cycles(3);

    foreach (vecs[i]) run_txn(vecs[i]);

    // Reset asserted mid-frame after four data bits have been clocked.
    offer(8'h30);
    wait_release(ok);
    check("rst_seq_request", int'(ok), 1);
    cycles(10);
    for (int i = 0; i < 4; i++) dev_pulse(b);
    check("pre_reset_dat_oe", int'(ps2_dat_oe), 1);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_clk_oe", int'(ps2_clk_oe), 0);
    check("async_rst_dat_oe", int'(ps2_dat_oe), 0);
    check("async_rst_ready",  int'(bus.cmd_ready), 1);
    check("async_rst_active", int'(tx_active), 0);
    cycles(3);
    resetn = 1'b1;
    cycles(2);
    check("post_rst_ready",  int'(bus.cmd_ready), 1);
    check("post_rst_clk_oe", int'(ps2_clk_oe), 0);
    run_txn(v_ff);

    check("tx_active_track", txa_bad_n, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
